mem_align_unit: RTL and testbench

MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

---
 rtl/mips_mem_pkg.sv | 19 +
 rtl/load_extend.sv | 33 +++
 rtl/mem_align_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_align_unit.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the memory alignment unit: access sizes and FSM states.
package mips_mem_pkg;

   // Access size encoding carried on i_size
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   // Request sequencing: IDLE accepts, ISSUE drives memory, WAIT covers read latency,
   // DONE presents the one-cycle result.
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half/word out of a memory word and extends it to full width.
module load_extend
   import mips_mem_pkg::*;
#(
   parameter int NB_DATA = 32
) (
   input  logic [NB_DATA-1:0] i_rdata,
   input  logic [1:0]         i_addr_lo,
   input  logic [1:0]         i_size,
   input  logic               i_unsigned,
   output logic [NB_DATA-1:0] o_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Little-endian lane select followed by sign or zero extension
   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      byte_sel = i_rdata[{i_addr_lo, 3'b000} +: 8];
      half_sel = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
      o_data   = '0;
      case (i_size)
         SZ_BYTE: o_data = i_unsigned ? {{(NB_DATA-8){1'b0}}, byte_sel}
                                      : {{(NB_DATA-8){byte_sel[7]}}, byte_sel};
         SZ_HALF: o_data = i_unsigned ? {{(NB_DATA-16){1'b0}}, half_sel}
                                      : {{(NB_DATA-16){half_sel[15]}}, half_sel};
         SZ_WORD: o_data = i_rdata;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: checks alignment, places store bytes on lanes,
// issues one memory access and returns the extended load result.
module mem_align_unit
   import mips_mem_pkg::*;
#(
   parameter int NB_DATA  = 32,
   parameter int NB_LANES = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_valid,
   output logic                o_ready,
   input  logic                i_mem_read,
   input  logic                i_mem_write,
   input  logic [1:0]          i_size,
   input  logic                i_unsigned,
   input  logic [NB_DATA-1:0]  i_addr,
   input  logic [NB_DATA-1:0]  i_wdata,
   output logic                o_mem_en,
   output logic [NB_LANES-1:0] o_mem_we,
   output logic [NB_DATA-1:0]  o_mem_addr,
   output logic [NB_DATA-1:0]  o_mem_wdata,
   input  logic [NB_DATA-1:0]  i_mem_rdata,
   output logic                o_valid,
   output logic [NB_DATA-1:0]  o_rdata,
   output logic                o_misaligned
);

   state_t               state_q, state_d;
   logic                 mem_en_q, mem_en_d;
   logic [NB_LANES-1:0]  mem_we_q, mem_we_d;
   logic [NB_DATA-1:0]   mem_addr_q, mem_addr_d;
   logic [NB_DATA-1:0]   mem_wdata_q, mem_wdata_d;
   logic                 valid_q, valid_d;
   logic [NB_DATA-1:0]   rdata_q, rdata_d;
   logic                 misaligned_q, misaligned_d;

   // Request fields held from acceptance until the result is produced
   logic                 is_load_q, is_load_d;
   logic [1:0]           size_q, size_d;
   logic                 unsigned_q, unsigned_d;
   logic [1:0]           addr_lo_q, addr_lo_d;

   logic                 req_take;
   logic                 req_err;
   logic [NB_LANES-1:0]  lane_we;
   logic [NB_DATA-1:0]   lane_wdata;
   logic [NB_DATA-1:0]   ext_data;

   // Decode the incoming request: error check and store lane placement
   always_comb begin
      req_take   = i_valid && (i_mem_read || i_mem_write);
      req_err    = 1'b0;
      lane_we    = '0;
      lane_wdata = '0;
      case (i_size)
         SZ_BYTE: begin
            lane_we    = NB_LANES'(1) << i_addr[1:0];
            lane_wdata = {NB_LANES{i_wdata[7:0]}};
         end
         SZ_HALF: begin
            req_err    = i_addr[0];
            lane_we    = NB_LANES'(3) << {i_addr[1], 1'b0};
            lane_wdata = {(NB_LANES/2){i_wdata[15:0]}};
         end
         SZ_WORD: begin
            req_err    = |i_addr[1:0];
            lane_we    = '1;
            lane_wdata = i_wdata;
         end
         default: req_err = 1'b1;
      endcase
      if (i_mem_read && i_mem_write) begin
         req_err = 1'b1;
      end
   end

   load_extend #(
      .NB_DATA (NB_DATA)
   ) u_load_extend (
      .i_rdata    (i_mem_rdata),
      .i_addr_lo  (addr_lo_q),
      .i_size     (size_q),
      .i_unsigned (unsigned_q),
      .o_data     (ext_data)
   );

   // Next-state and next-output logic; every output is registered
   always_comb begin
      state_d      = state_q;
      mem_en_d     = 1'b0;
      mem_we_d     = '0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      valid_d      = 1'b0;
      rdata_d      = '0;
      misaligned_d = 1'b0;
      is_load_d    = is_load_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      addr_lo_d    = addr_lo_q;
      case (state_q)
         IDLE: begin
            if (req_take) begin
               is_load_d  = i_mem_read;
               size_d     = i_size;
               unsigned_d = i_unsigned;
               addr_lo_d  = i_addr[1:0];
               if (req_err) begin
                  state_d      = DONE;
                  valid_d      = 1'b1;
                  misaligned_d = 1'b1;
               end else begin
                  state_d     = ISSUE;
                  mem_en_d    = 1'b1;
                  mem_addr_d  = {i_addr[NB_DATA-1:2], 2'b00};
                  mem_we_d    = i_mem_write ? lane_we : '0;
                  mem_wdata_d = i_mem_write ? lane_wdata : '0;
               end
            end
         end
         ISSUE: begin
            if (is_load_q) begin
               state_d = WAIT;
            end else begin
               state_d = DONE;
               valid_d = 1'b1;
            end
         end
         WAIT: begin
            state_d = DONE;
            valid_d = 1'b1;
            rdata_d = ext_data;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state and outputs with synchronous reset
   // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q      <= IDLE;
         mem_en_q     <= 1'b0;
         mem_we_q     <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         valid_q      <= 1'b0;
         rdata_q      <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         valid_q      <= valid_d;
         rdata_q      <= rdata_d;
         misaligned_q <= misaligned_d;
      end
   end

   // Request field capture
   // NOTE: these carry no reset; they are only read after being loaded at acceptance.
   always_ff @(posedge i_clk) begin
      is_load_q  <= is_load_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_lo_q  <= addr_lo_d;
   end

   assign o_ready      = (state_q == IDLE);
   assign o_mem_en     = mem_en_q;
   assign o_mem_we     = mem_we_q;
   assign o_mem_addr   = mem_addr_q;
   assign o_mem_wdata  = mem_wdata_q;
   assign o_valid      = valid_q;
   assign o_rdata      = rdata_q;
   assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed testbench for mem_align_unit.
module tb_mem_align_unit;
   import mips_mem_pkg::*;

   localparam logic [31:0] JUNK = 32'h5A5A_C3C3;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_valid;
   logic        o_ready;
   logic        i_mem_read;
   logic        i_mem_write;
   logic [1:0]  i_size;
   logic        i_unsigned;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_mem_en;
   logic [3:0]  o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic [31:0] i_mem_rdata;
   logic        o_valid;
   logic [31:0] o_rdata;
   logic        o_misaligned;

   int checks = 0;
   int errors = 0;

   // Results gathered by do_op
   int          r_valid_cyc;
   int          r_en_cnt;
   logic [3:0]  r_we;
   logic [31:0] r_maddr;
   logic [31:0] r_mwdata;
   logic [31:0] r_rdata;
   logic        r_mis;
   logic        r_inv_bad;
   logic        r_ready_after;

   mem_align_unit #(
      .NB_DATA  (32),
      .NB_LANES (4)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_mem_read   (i_mem_read),
      .i_mem_write  (i_mem_write),
      .i_size       (i_size),
      .i_unsigned   (i_unsigned),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_mem_en     (o_mem_en),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .i_mem_rdata  (i_mem_rdata),
      .o_valid      (o_valid),
      .o_rdata      (o_rdata),
      .o_misaligned (o_misaligned)
   );

   always #5 i_clk = ~i_clk;

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One request from acceptance to result; memory answers one cycle after o_mem_en
   task automatic do_op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rword);
      logic en_prev;
      i_valid     = 1'b1;
      i_mem_read  = rd;
      i_mem_write = wr;
      i_size      = sz;
      i_unsigned  = uns;
      i_addr      = addr;
      i_wdata     = wdata;
      i_mem_rdata = JUNK;
      r_valid_cyc = -1;
      r_en_cnt    = 0;
      r_we        = '0;
      r_maddr     = '0;
      r_mwdata    = '0;
      r_rdata     = '0;
      r_mis       = 1'b0;
      r_inv_bad   = !o_ready;
      en_prev     = 1'b0;
      tick();
      i_valid     = 1'b0;
      i_mem_read  = 1'b0;
      i_mem_write = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         i_mem_rdata = en_prev ? rword : JUNK;
         if (o_mem_en) begin
            r_en_cnt++;
            r_we     = o_mem_we;
            r_maddr  = o_mem_addr;
            r_mwdata = o_mem_wdata;
         end else if (o_mem_we != 4'b0000) begin
            r_inv_bad = 1'b1;
         end
         if (!o_valid && (o_rdata != 32'h0 || o_misaligned)) r_inv_bad = 1'b1;
         if (o_ready) r_inv_bad = 1'b1;
         en_prev = o_mem_en;
         if (o_valid) begin
            r_valid_cyc = k;
            r_rdata     = o_rdata;
            r_mis       = o_misaligned;
            break;
         end
         tick();
      end
      tick();
      i_mem_rdata   = JUNK;
      r_ready_after = o_ready && !o_valid && !o_mem_en;
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
      i_size = SZ_WORD; i_unsigned = 1'b0; i_addr = '0; i_wdata = '0; i_mem_rdata = JUNK;
      tick();
      tick();
      checks++;
      if ({o_ready, o_valid, o_mem_en, o_mem_we, o_misaligned, o_rdata} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0}) begin
         errors++;
         $display("FAIL reset_state got rdy=%b vld=%b en=%b we=%b mis=%b rdata=%h want 1 0 0 0000 0 0",
                  o_ready, o_valid, o_mem_en, o_mem_we, o_misaligned, o_rdata);
      end
      i_reset = 1'b0;
      tick();
   endtask

   task automatic test_store();
      // Byte store into lane 2
      do_op(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0006, 32'h0000_00AB, JUNK);
      checks++;
      if ({r_en_cnt, r_we, r_maddr, r_mwdata} !== {32'd1, 4'b0100, 32'h0000_0004, 32'hABAB_ABAB}) begin
         errors++;
         $display("FAIL sb_issue got en=%0d we=%b addr=%h wdata=%h want 1 0100 00000004 ababab",
                  r_en_cnt, r_we, r_maddr, r_mwdata);
      end
      checks++;
      if ({r_valid_cyc, r_rdata, r_mis, r_inv_bad, r_ready_after} !== {32'd2, 32'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL sb_done got cyc=%0d rdata=%h mis=%b inv=%b rdy=%b want 2 0 0 0 1",
                  r_valid_cyc, r_rdata, r_mis, r_inv_bad, r_ready_after);
      end
      // Half store into the upper half
      do_op(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0106, 32'hFFFF_1234, JUNK);
      checks++;
      if ({r_valid_cyc, r_we, r_maddr, r_mwdata, r_inv_bad} !== {32'd2, 4'b1100, 32'h0000_0104, 32'h1234_1234, 1'b0}) begin
         errors++;
         $display("FAIL sh_upper got cyc=%0d we=%b addr=%h wdata=%h inv=%b want 2 1100 00000104 12341234 0",
                  r_valid_cyc, r_we, r_maddr, r_mwdata, r_inv_bad);
      end
      // Half store into the lower half
      do_op(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h0000_0200, 32'h0000_BEEF, JUNK);
      checks++;
      if ({r_valid_cyc, r_we, r_maddr, r_mwdata} !== {32'd2, 4'b0011, 32'h0000_0200, 32'hBEEF_BEEF}) begin
         errors++;
         $display("FAIL sh_lower got cyc=%0d we=%b addr=%h wdata=%h want 2 0011 00000200 beefbeef",
                  r_valid_cyc, r_we, r_maddr, r_mwdata);
      end
   endtask

   task automatic test_load();
      // Signed half from the upper half of the word
      do_op(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0012, 32'h0, 32'h8001_7FFF);
      checks++;
      if ({r_en_cnt, r_we, r_maddr} !== {32'd1, 4'b0000, 32'h0000_0010}) begin
         errors++;
         $display("FAIL lh_issue got en=%0d we=%b addr=%h want 1 0000 00000010", r_en_cnt, r_we, r_maddr);
      end
      checks++;
      if ({r_valid_cyc, r_rdata, r_mis, r_inv_bad, r_ready_after} !== {32'd3, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL lh_signed got cyc=%0d rdata=%h mis=%b inv=%b rdy=%b want 3 ffff8001 0 0 1",
                  r_valid_cyc, r_rdata, r_mis, r_inv_bad, r_ready_after);
      end
      // Same access zero-extended
      do_op(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0012, 32'h0, 32'h8001_7FFF);
      checks++;
      if ({r_valid_cyc, r_rdata} !== {32'd3, 32'h0000_8001}) begin
         errors++;
         $display("FAIL lhu got cyc=%0d rdata=%h want 3 00008001", r_valid_cyc, r_rdata);
      end
      // Signed byte from lane 1
      do_op(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0001, 32'h0, 32'h0000_8000);
      checks++;
      if ({r_valid_cyc, r_rdata} !== {32'd3, 32'hFFFF_FF80}) begin
         errors++;
         $display("FAIL lb_signed got cyc=%0d rdata=%h want 3 ffffff80", r_valid_cyc, r_rdata);
      end
      // Unsigned byte from lane 3
      do_op(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0023, 32'h0, 32'h9A00_0000);
      checks++;
      if ({r_valid_cyc, r_maddr, r_rdata} !== {32'd3, 32'h0000_0020, 32'h0000_009A}) begin
         errors++;
         $display("FAIL lbu_lane3 got cyc=%0d addr=%h rdata=%h want 3 00000020 0000009a",
                  r_valid_cyc, r_maddr, r_rdata);
      end
      // Aligned word
      do_op(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D);
      checks++;
      if ({r_valid_cyc, r_maddr, r_rdata} !== {32'd3, 32'h0000_0040, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL lw got cyc=%0d addr=%h rdata=%h want 3 00000040 cafef00d",
                  r_valid_cyc, r_maddr, r_rdata);
      end
   endtask

   task automatic test_errors();
      logic        rd_v [4];
      logic        wr_v [4];
      logic [1:0]  sz_v [4];
      logic [31:0] ad_v [4];
      rd_v[0] = 1'b1; wr_v[0] = 1'b0; sz_v[0] = SZ_WORD; ad_v[0] = 32'h0000_0002;
      rd_v[1] = 1'b1; wr_v[1] = 1'b0; sz_v[1] = SZ_ILL;  ad_v[1] = 32'h0000_0000;
      rd_v[2] = 1'b0; wr_v[2] = 1'b1; sz_v[2] = SZ_HALF; ad_v[2] = 32'h0000_0001;
      rd_v[3] = 1'b1; wr_v[3] = 1'b1; sz_v[3] = SZ_WORD; ad_v[3] = 32'h0000_0008;
      for (int i = 0; i < 4; i++) begin
         do_op(rd_v[i], wr_v[i], sz_v[i], 1'b0, ad_v[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF);
         checks++;
         if ({r_valid_cyc, r_en_cnt, r_mis, r_rdata, r_inv_bad, r_ready_after}
             !== {32'd1, 32'd0, 1'b1, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL err_case%0d got cyc=%0d en=%0d mis=%b rdata=%h inv=%b rdy=%b want 1 0 1 0 0 1",
                     i, r_valid_cyc, r_en_cnt, r_mis, r_rdata, r_inv_bad, r_ready_after);
         end
      end
   endtask

   task automatic test_no_op();
      logic bad;
      bad = 1'b0;
      i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = SZ_WORD; i_addr = 32'h0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (!o_ready || o_mem_en || o_valid) bad = 1'b1;
      end
      i_valid = 1'b0;
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL no_op_ignored got bad=%b want 0", bad);
      end
   endtask

   task automatic test_reset_mid_op();
      logic saw_valid;
      // Reset sampled at the end of WAIT of a load
      i_valid = 1'b1; i_mem_read = 1'b1; i_size = SZ_WORD; i_unsigned = 1'b0; i_addr = 32'h0000_0040;
      tick();
      i_valid = 1'b0; i_mem_read = 1'b0;
      tick();
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      checks++;
      if ({o_ready, o_valid, o_mem_en} !== 3'b100) begin
         errors++;
         $display("FAIL rst_wait got rdy=%b vld=%b en=%b want 1 0 0", o_ready, o_valid, o_mem_en);
      end
      saw_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (o_valid) saw_valid = 1'b1;
      end
      checks++;
      if (saw_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_no_pulse got valid_seen=%b want 0", saw_valid);
      end
      // Store following the aborted load completes normally
      do_op(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, JUNK);
      checks++;
      if ({r_valid_cyc, r_we, r_maddr, r_mwdata, r_inv_bad} !== {32'd2, 4'b1111, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0}) begin
         errors++;
         $display("FAIL sw_after_rst got cyc=%0d we=%b addr=%h wdata=%h inv=%b want 2 1111 00000008 deadbeef 0",
                  r_valid_cyc, r_we, r_maddr, r_mwdata, r_inv_bad);
      end
      // Reset sampled while a store is in ISSUE
      i_valid = 1'b1; i_mem_write = 1'b1; i_size = SZ_WORD; i_addr = 32'h0000_000C; i_wdata = 32'h1111_2222;
      tick();
      i_valid = 1'b0; i_mem_write = 1'b0;
      i_reset = 1'b1;
      checks++;
      if (o_mem_en !== 1'b1) begin
         errors++;
         $display("FAIL rst_issue_pre got en=%b want 1", o_mem_en);
      end
      tick();
      i_reset = 1'b0;
      checks++;
      if ({o_mem_en, o_mem_we, o_ready, o_valid} !== {1'b0, 4'b0000, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL rst_issue got en=%b we=%b rdy=%b vld=%b want 0 0000 1 0", o_mem_en, o_mem_we, o_ready, o_valid);
      end
      saw_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (o_valid) saw_valid = 1'b1;
      end
      checks++;
      if (saw_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_issue_no_pulse got valid_seen=%b want 0", saw_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0]  en_vec, valid_vec, ready_vec;
      logic [31:0] wd1, wd2;
      en_vec = '0; valid_vec = '0; ready_vec = '0; wd1 = '0; wd2 = '0;
      i_valid = 1'b1; i_mem_write = 1'b1; i_mem_read = 1'b0; i_size = SZ_BYTE;
      i_addr = 32'h0000_0000; i_wdata = 32'h0000_0011;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) begin
            i_wdata = 32'h0000_0022;
            wd1     = o_mem_wdata;
         end
         if (k == 4) wd2 = o_mem_wdata;
         en_vec[k]    = o_mem_en;
         valid_vec[k] = o_valid;
         ready_vec[k] = o_ready;
      end
      i_valid = 1'b0; i_mem_write = 1'b0;
      repeat (4) tick();
      checks++;
      if ({en_vec, valid_vec, ready_vec} !== {7'b0010010, 7'b0100100, 7'b1001000}) begin
         errors++;
         $display("FAIL b2b_timing got en=%b vld=%b rdy=%b want 0010010 0100100 1001000",
                  en_vec, valid_vec, ready_vec);
      end
      checks++;
      if ({wd1, wd2} !== {32'h1111_1111, 32'h2222_2222}) begin
         errors++;
         $display("FAIL b2b_data got wd1=%h wd2=%h want 11111111 22222222", wd1, wd2);
      end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_errors();
      test_no_op();
      test_reset_mid_op();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout got unfinished want finished");
      $fatal(1, "timeout");
   end

endmodule
